// File: rtl/cpu_clk_gen.sv
// Runtime-programmable CPU clock divider with run/halt/single-step modes,
// ratio reload on period boundaries, tick strobes and a rising-edge counter.
module cpu_clk_gen #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 50000000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic             step_req,
  input  logic [CNT_W-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic             busy,
  output logic [31:0]      cycles
);

  localparam logic [CNT_W-1:0] DIV_RST   = CNT_W'(DEFAULT_DIV);
  localparam logic [1:0]       MODE_RUN  = 2'b00;
  localparam logic [1:0]       MODE_STEP = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       div_q, div_d;
  logic [CNT_W-1:0]       shadow_q, shadow_d;
  logic                   pending_q, pending_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   step_prev_q;
  logic                   clk_out_q, clk_out_d;
  logic                   tick_rise_q, tick_rise_d;
  logic                   tick_fall_q, tick_fall_d;
  logic [31:0]            cycles_q, cycles_d;

  logic step_edge;
  logic terminal;
  logic rise_term;
  logic fall_term;
  logic apply;

  // step_req is asynchronous; only a clean synchronised rising edge counts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q      <= '0;
      step_prev_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], step_req};
      step_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign step_edge = sync_q[SYNC_STAGES-1] & ~step_prev_q;

  assign terminal  = (state_q != S_IDLE) && (cnt_q == div_q);
  assign rise_term = terminal && !clk_out_q;
  assign fall_term = terminal &&  clk_out_q;

  // A new ratio only takes effect on a half-period boundary or while idle,
  // so a running period is never truncated.
  assign apply = (state_q == S_IDLE) || terminal;

  always_comb begin
    div_d     = div_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    if (apply && pending_q) begin
      div_d = shadow_q;
    end
    if (div_load) begin
      shadow_d  = div_val;
      pending_d = 1'b1;
    end else if (apply) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (mode == MODE_RUN) begin
          state_d = S_RUN;
        end else if ((mode == MODE_STEP) && step_edge) begin
          state_d = S_STEP;
        end
      end
      S_RUN: begin
        if (fall_term && (mode != MODE_RUN)) begin
          state_d = S_IDLE;
        end
      end
      S_STEP: begin
        if (fall_term) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Ticks are registered alongside clk_out so all three change together.
  always_comb begin
    cnt_d       = '0;
    clk_out_d   = 1'b0;
    tick_rise_d = 1'b0;
    tick_fall_d = 1'b0;
    cycles_d    = cycles_q + {31'd0, rise_term};
    if (state_q != S_IDLE) begin
      tick_rise_d = rise_term;
      tick_fall_d = fall_term;
      if (terminal) begin
        cnt_d     = '0;
        clk_out_d = ~clk_out_q;
      end else begin
        cnt_d     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        clk_out_d = clk_out_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      div_q       <= DIV_RST;
      shadow_q    <= DIV_RST;
      pending_q   <= 1'b0;
      clk_out_q   <= 1'b0;
      tick_rise_q <= 1'b0;
      tick_fall_q <= 1'b0;
      cycles_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      clk_out_q   <= clk_out_d;
      tick_rise_q <= tick_rise_d;
      tick_fall_q <= tick_fall_d;
      cycles_q    <= cycles_d;
    end
  end

  assign clk_out   = clk_out_q;
  assign tick_rise = tick_rise_q;
  assign tick_fall = tick_fall_q;
  assign busy      = (state_q != S_IDLE);
  assign cycles    = cycles_q;

endmodule

// File: tb/tb_cpu_clk_gen.sv
// Bench for cpu_clk_gen: a countdown-based reference model compared every
// cycle, directed scenarios with literal expectations, then random stimulus.
module tb_cpu_clk_gen;

  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        step_req;
  logic [31:0] div_val;
  logic        div_load;
  logic        clk_out, tick_rise, tick_fall, busy;
  logic [31:0] cycles;

  cpu_clk_gen #(.CNT_W(32), .DEFAULT_DIV(3), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .step_req(step_req),
    .div_val(div_val), .div_load(div_load), .clk_out(clk_out),
    .tick_rise(tick_rise), .tick_fall(tick_fall), .busy(busy),
    .cycles(cycles)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference model: phase 0 idle, 1 run, 2 step; left = cycles until next toggle.
  bit          m_valid = 0;
  bit          chk_en  = 1;
  int          m_phase, m_left;
  bit          m_clk, m_tr, m_tf, m_pend;
  logic [31:0] m_cyc, m_div, m_shadow;
  bit          h [0:SS];

  always @(posedge clk) begin
    bit edge_seen, apply, fell;
    if (!rst_n) begin
      m_valid = 1; m_phase = 0; m_left = 0;
      m_clk = 0; m_tr = 0; m_tf = 0; m_pend = 0;
      m_cyc = 0; m_div = 3; m_shadow = 3;
      for (int i = 0; i <= SS; i++) h[i] = 0;
    end else if (m_valid) begin
      edge_seen = h[SS-1] && !h[SS];
      m_tr = 0; m_tf = 0; apply = 0; fell = 0;
      if (m_phase == 0) begin
        apply = 1;
        if (m_pend) m_div = m_shadow;
        if (mode == 2'b00) begin m_phase = 1; m_left = int'(m_div) + 1; end
        else if (mode == 2'b01 && edge_seen) begin m_phase = 2; m_left = int'(m_div) + 1; end
      end else begin
        m_left--;
        if (m_left == 0) begin
          apply = 1;
          if (m_pend) m_div = m_shadow;
          m_clk = !m_clk;
          if (m_clk) begin m_tr = 1; m_cyc = m_cyc + 1; end
          else begin m_tf = 1; fell = 1; end
          m_left = int'(m_div) + 1;
          if (fell && (m_phase == 2 || mode != 2'b00)) m_phase = 0;
        end
      end
      if (div_load) begin m_shadow = div_val; m_pend = 1; end
      else if (apply) m_pend = 0;
      for (int i = SS; i > 0; i--) h[i] = h[i-1];
      h[0] = step_req;
    end
  end

  always @(negedge clk) begin
    if (m_valid && chk_en) begin
      check("clk_out",   {31'd0, clk_out},   {31'd0, m_clk});
      check("tick_rise", {31'd0, tick_rise}, {31'd0, m_tr});
      check("tick_fall", {31'd0, tick_fall}, {31'd0, m_tf});
      check("busy",      {31'd0, busy},      {31'd0, (m_phase != 0)});
      check("cycles",    cycles,             m_cyc);
    end
  end

  task automatic wait_tick(output int n);
    bit hit = 0;
    n = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      n++;
      hit = tick_rise || tick_fall;
    end
    check("tick_timeout", {31'd0, hit}, 32'd1);
  endtask

  task automatic wait_rise();
    bit hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      hit = tick_rise;
    end
    check("rise_timeout", {31'd0, hit}, 32'd1);
  endtask

  task automatic wait_fall();
    bit hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      hit = tick_fall;
    end
    check("fall_timeout", {31'd0, hit}, 32'd1);
  endtask

  // mode=00 presented before the first active edge: rise lands on the 5th edge.
  task automatic entry_check(input string tag);
    for (int k = 1; k <= 4; k++) @(negedge clk);
    check({tag, "_pre_rise_low"}, {31'd0, clk_out}, 32'd0);
    @(negedge clk);
    check({tag, "_first_rise"}, {30'd0, clk_out, tick_rise}, 32'd3);
    check({tag, "_first_cycles"}, cycles, 32'd1);
  endtask

  initial begin
    int n, rises, busy_cnt, r;
    logic [31:0] cyc0;
    rst_n = 0; mode = 2'b10; step_req = 0; div_val = 0; div_load = 0;
    repeat (3) @(negedge clk);
    check("rst_clk_out", {31'd0, clk_out}, 32'd0);
    check("rst_cycles", cycles, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1; mode = 2'b00;

    // Free run at the default ratio: half period 4.
    entry_check("run");
    wait_tick(n); check("run_half_hi", n, 4); check("run_fall", {31'd0, tick_fall}, 32'd1);
    wait_tick(n); check("run_half_lo", n, 4); check("run_cycles2", cycles, 2);
    wait_tick(n); wait_tick(n); check("run_cycles3", cycles, 3);

    // Reload mid half-period: current half keeps 4, then halves of 2.
    div_load = 1; div_val = 1;
    @(negedge clk); div_load = 0;
    wait_tick(n); check("reload_keep", n + 1, 4);
    wait_tick(n); check("reload_new", n, 2);
    div_load = 1; div_val = 3;
    @(negedge clk); div_load = 0;
    wait_tick(n); wait_tick(n);
    // Two loads before one terminal: the last one (0) wins.
    div_load = 1; div_val = 5;
    @(negedge clk); div_val = 0;
    @(negedge clk); div_load = 0;
    wait_tick(n); check("b2b_keep", n + 2, 4);
    wait_tick(n); check("b2b_div0_a", n, 1);
    wait_tick(n); check("b2b_div0_b", n, 1);
    div_load = 1; div_val = 3;
    @(negedge clk); div_load = 0;
    repeat (4) wait_tick(n);

    // Halt with clk_out high: full period completes, then idle low.
    wait_rise();
    mode = 2'b10;
    wait_tick(n);
    check("halt_half", n, 4);
    check("halt_fall_busy", {30'd0, tick_fall, busy}, 32'd2);
    repeat (10) @(negedge clk);
    check("halt_idle", {30'd0, clk_out, busy}, 32'd0);

    // Single step with a glitchy button: exactly one period.
    mode = 2'b01; cyc0 = cycles; rises = 0; busy_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step_req = (k == 0 || k == 2 || k >= 4) && k < 24;
      @(negedge clk);
      rises += int'(tick_rise);
      busy_cnt += int'(busy);
    end
    check("step_rises", rises, 1);
    check("step_busy_len", busy_cnt, 8);
    check("step_cycles", cycles, cyc0 + 1);
    step_req = 0;
    repeat (4) @(negedge clk);

    // Reset mid-run while high; reset restores the default ratio.
    div_load = 1; div_val = 1;
    @(negedge clk); div_load = 0; mode = 2'b00;
    wait_rise();
    rst_n = 0;
    @(negedge clk);
    check("midrst_state", {27'd0, clk_out, tick_rise, tick_fall, busy, 1'b0}, 32'd0);
    check("midrst_cycles", cycles, 32'd0);
    rst_n = 1;
    entry_check("postrst");

    // Counter wrap: preset to all-ones while idle.
    mode = 2'b10;
    wait_fall();
    @(negedge clk);
    chk_en = 0;
    force dut.cycles_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.cycles_q;
    m_cyc = 32'hFFFF_FFFF;
    @(negedge clk);
    chk_en = 1;
    mode = 2'b00;
    wait_rise();
    check("wrap_cycles", cycles, 32'd0);

    // Random stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      div_load = 0; rst_n = 1;
      if ($urandom_range(0, 29) == 0) begin
        r = int'($urandom_range(0, 9));
        mode = (r < 5) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
      end
      if ($urandom_range(0, 5) == 0) step_req = ~step_req;
      if ($urandom_range(0, 24) == 0) begin div_load = 1; div_val = $urandom_range(0, 4); end
      if ($urandom_range(0, 399) == 0) rst_n = 0;
    end
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
